// File: rtl/instruction_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit_if
//
// Purpose: groups the three buses around the instruction fetch unit:
//   - program counter control (pc_value in, enable/inc/load strobes out)
//   - byte-wide instruction memory read port with a ready handshake
//   - decoder-facing instruction stream with valid/ready plus the
//     redirect (jump_req/jump_target) and halt requests
//
// Modports:
//   master : the fetch unit (drives strobes, mem_rd/mem_addr, instr/valid)
//   slave  : the environment (PC, memory and decoder)
// ----------------------------------------------------------------------------
interface instruction_fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
);
    // Program counter side
    logic [ADDR_WIDTH-1:0]   pc_value;
    logic                    pc_enOut;
    logic                    pc_inc;
    logic                    pc_load;
    logic [ADDR_WIDTH-1:0]   pc_in_value;

    // Instruction memory side
    logic                    mem_rd;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_data;
    logic                    mem_ready;

    // Decoder side
    logic [2*DATA_WIDTH-1:0] instr;
    logic                    instr_valid;
    logic                    instr_ready;
    logic                    jump_req;
    logic [ADDR_WIDTH-1:0]   jump_target;
    logic                    halt;
    logic                    halted;

    modport master (
        input  pc_value,
        input  mem_data,
        input  mem_ready,
        input  instr_ready,
        input  jump_req,
        input  jump_target,
        input  halt,
        output pc_enOut,
        output pc_inc,
        output pc_load,
        output pc_in_value,
        output mem_rd,
        output mem_addr,
        output instr,
        output instr_valid,
        output halted
    );

    modport slave (
        output pc_value,
        output mem_data,
        output mem_ready,
        output instr_ready,
        output jump_req,
        output jump_target,
        output halt,
        input  pc_enOut,
        input  pc_inc,
        input  pc_load,
        input  pc_in_value,
        input  mem_rd,
        input  mem_addr,
        input  instr,
        input  instr_valid,
        input  halted
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose: controls an external program counter and fetches 16-bit
// instructions as two consecutive bytes (hi first, then lo) from a byte-wide
// instruction memory. Each completed instruction is offered to the decoder on
// a valid/ready handshake; on that handshake the decoder may halt the unit or
// redirect it to a new address, which is applied through a one-cycle PC load.
//
// Ports:
//   i_clk    : system clock, rising edge
//   i_reset  : asynchronous, active-high reset
//   io_bus   : instruction_fetch_unit_if.master
//              pc_value / pc_enOut / pc_inc / pc_load / pc_in_value
//              mem_rd / mem_addr / mem_data / mem_ready
//              instr / instr_valid / instr_ready
//              jump_req / jump_target / halt / halted
//
// Timing: with a zero-wait memory one instruction is presented every three
// cycles (two fetch cycles plus the handshake cycle); a jump adds one cycle.
// ----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    instruction_fetch_unit_if.master  io_bus
);

    typedef enum logic [2:0] {
        StIdle,
        StFetchHi,
        StFetchLo,
        StPresent,
        StLoad,
        StHalted
    } state_e;

    state_e                  r_state;
    state_e                  w_state_d;

    logic [DATA_WIDTH-1:0]   r_hi;
    logic [DATA_WIDTH-1:0]   w_hi_d;
    logic [2*DATA_WIDTH-1:0] r_instr;
    logic [2*DATA_WIDTH-1:0] w_instr_d;
    logic [ADDR_WIDTH-1:0]   r_target;
    logic [ADDR_WIDTH-1:0]   w_target_d;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= StIdle;
            r_hi     <= '0;
            r_instr  <= '0;
            r_target <= '0;
        end else begin
            r_state  <= w_state_d;
            r_hi     <= w_hi_d;
            r_instr  <= w_instr_d;
            r_target <= w_target_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d          = r_state;
        w_hi_d             = r_hi;
        w_instr_d          = r_instr;
        w_target_d         = r_target;

        io_bus.pc_enOut    = 1'b0;
        io_bus.pc_inc      = 1'b0;
        io_bus.pc_load     = 1'b0;
        io_bus.mem_rd      = 1'b0;
        io_bus.mem_addr    = '0;
        io_bus.instr_valid = 1'b0;
        io_bus.halted      = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_state_d = StFetchHi;
            end

            StFetchHi: begin
                io_bus.pc_enOut = 1'b1;
                io_bus.mem_rd   = 1'b1;
                io_bus.mem_addr = io_bus.pc_value;
                // The PC steps on the very edge that completes the read, so
                // the next byte address is ready when FETCH_LO starts.
                io_bus.pc_inc   = io_bus.mem_ready;
                if (io_bus.mem_ready) begin
                    w_hi_d    = io_bus.mem_data;
                    w_state_d = StFetchLo;
                end
            end

            StFetchLo: begin
                io_bus.pc_enOut = 1'b1;
                io_bus.mem_rd   = 1'b1;
                io_bus.mem_addr = io_bus.pc_value;
                io_bus.pc_inc   = io_bus.mem_ready;
                if (io_bus.mem_ready) begin
                    // instr only changes when a whole instruction is in hand,
                    // so the decoder never sees a half-updated word.
                    w_instr_d = {r_hi, io_bus.mem_data};
                    w_state_d = StPresent;
                end
            end

            StPresent: begin
                io_bus.instr_valid = 1'b1;
                // halt and jump_req only matter on the handshake edge.
                if (io_bus.instr_ready) begin
                    if (io_bus.halt) begin
                        w_state_d = StHalted;
                    end else if (io_bus.jump_req) begin
                        w_target_d = io_bus.jump_target;
                        w_state_d  = StLoad;
                    end else begin
                        w_state_d = StFetchHi;
                    end
                end
            end

            StLoad: begin
                io_bus.pc_load = 1'b1;
                w_state_d      = StFetchHi;
            end

            StHalted: begin
                io_bus.halted = 1'b1;
            end

            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign io_bus.instr       = r_instr;
    assign io_bus.pc_in_value = r_target;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    instruction_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .io_bus  (bus)
    );

    // Environment: program counter, wait-state memory
    logic [7:0] mem [256];
    logic [7:0] pc;
    int         wait_cfg;
    int         wait_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst)              pc <= 8'h00;
        else if (bus.pc_load) pc <= bus.pc_in_value;
        else if (bus.pc_inc)  pc <= pc + 8'h01;
    end

    always @(posedge clk or posedge rst) begin
        if (rst)                               wait_cnt <= 0;
        else if (bus.mem_rd && !bus.mem_ready) wait_cnt <= wait_cnt + 1;
        else                                   wait_cnt <= 0;
    end

    assign bus.pc_value  = pc;
    assign bus.mem_ready = bus.mem_rd && (wait_cnt >= wait_cfg);
    assign bus.mem_data  = bus.mem_ready ? mem[bus.mem_addr] : 8'hEE;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: expected instructions queued before each fetch, compared
    // when the decoder handshake is about to happen.
    logic [15:0] exp_q [$];

    always @(negedge clk) begin
        if (!rst && bus.instr_valid && bus.instr_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got 0x%0h expected none", bus.instr);
            end else begin
                check("sb_instr", bus.instr, exp_q.pop_front());
            end
        end
    end

    typedef struct {
        int         wait_n;
        int         bp;
        logic       jump;
        logic       halt;
        logic [7:0] target;
        logic       poke_zero;
        logic [7:0] exp_addr;
        logic [15:0] exp_instr;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vec_t       v;
        logic [7:0] nxt;
        int         lat;

        vecs[0] = '{0, 0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'hABCD};
        vecs[1] = '{2, 0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 16'h1122};
        vecs[2] = '{0, 4, 1'b1, 1'b0, 8'h40, 1'b0, 8'h04, 16'h3344};
        vecs[3] = '{1, 1, 1'b1, 1'b0, 8'hFF, 1'b0, 8'h40, 16'h5566};
        vecs[4] = '{0, 0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 16'h1234};
        vecs[5] = '{0, 2, 1'b1, 1'b1, 8'h80, 1'b0, 8'h01, 16'hCD11};

        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h00] = 8'hAB; mem[8'h01] = 8'hCD;
        mem[8'h02] = 8'h11; mem[8'h03] = 8'h22;
        mem[8'h04] = 8'h33; mem[8'h05] = 8'h44;
        mem[8'h40] = 8'h55; mem[8'h41] = 8'h66;
        mem[8'hFF] = 8'h12;

        wait_cfg        = 0;
        bus.instr_ready = 1'b0;
        bus.jump_req    = 1'b0;
        bus.jump_target = 8'h00;
        bus.halt        = 1'b0;

        // Reset state
        step();
        step();
        check("rst_valid",   bus.instr_valid, 1'b0);
        check("rst_instr",   bus.instr, 16'h0000);
        check("rst_halted",  bus.halted, 1'b0);
        check("rst_pc_in",   bus.pc_in_value, 8'h00);
        check("rst_strobes", {bus.mem_rd, bus.pc_enOut, bus.pc_inc, bus.pc_load}, 4'b0000);

        // Zero-wait fetch from reset release
        rst = 1'b0;
        check("idle_rd", bus.mem_rd, 1'b0);
        step();
        check("hi_addr", bus.mem_addr, 8'h00);
        check("hi_rd_en_inc", {bus.mem_rd, bus.pc_enOut, bus.pc_inc}, 3'b111);
        step();
        check("lo_addr", bus.mem_addr, 8'h01);
        check("lo_inc",  bus.pc_inc, 1'b1);
        check("lo_pc",   pc, 8'h01);
        step();
        check("first_valid", bus.instr_valid, 1'b1);
        check("first_instr", bus.instr, 16'hABCD);
        check("first_pc",    pc, 8'h02);

        // Table-driven instruction stream
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            bus.instr_ready = 1'b0;
            bus.jump_req    = 1'b0;
            bus.halt        = 1'b0;
            wait_cfg        = v.wait_n;
            if (v.poke_zero) mem[8'h00] = 8'h34;
            exp_q.push_back(v.exp_instr);
            nxt = v.exp_addr + 8'h02;

            lat = 0;
            while (!bus.instr_valid && lat < 40) begin
                check("inc_xor_load", bus.pc_inc & bus.pc_load, 1'b0);
                if (bus.mem_rd) begin
                    check("fetch_addr", bus.mem_addr, pc);
                    check("inc_on_ready", bus.pc_inc, bus.mem_ready);
                end
                step();
                lat++;
            end
            if (i > 0) check("latency", lat, 2 * (v.wait_n + 1));
            check("valid", bus.instr_valid, 1'b1);
            check("pc_after_fetch", pc, nxt);

            // Backpressure: requests without a handshake must be ignored
            for (int b = 0; b < v.bp; b++) begin
                bus.jump_req    = 1'b1;
                bus.halt        = 1'b1;
                bus.jump_target = 8'hEE;
                step();
                check("bp_valid", bus.instr_valid, 1'b1);
                check("bp_instr", bus.instr, v.exp_instr);
                check("bp_rd",    bus.mem_rd, 1'b0);
                check("bp_pc",    pc, nxt);
            end

            bus.jump_req    = v.jump;
            bus.halt        = v.halt;
            bus.jump_target = v.target;
            bus.instr_ready = 1'b1;
            step();
            bus.instr_ready = 1'b0;
            bus.jump_req    = 1'b0;
            bus.halt        = 1'b0;

            if (v.halt) begin
                check("halt_halted", bus.halted, 1'b1);
                check("halt_no_load", bus.pc_load, 1'b0);
                check("halt_valid", bus.instr_valid, 1'b0);
                repeat (3) step();
                check("halt_stays", {bus.halted, bus.mem_rd, bus.pc_inc, bus.pc_load}, 4'b1000);
            end else if (v.jump) begin
                check("load_strobe", bus.pc_load, 1'b1);
                check("load_value",  bus.pc_in_value, v.target);
                check("load_no_inc", bus.pc_inc, 1'b0);
                step();
                check("jump_rd",   bus.mem_rd, 1'b1);
                check("jump_addr", bus.mem_addr, v.target);
            end else begin
                check("next_rd",   bus.mem_rd, 1'b1);
                check("next_addr", bus.mem_addr, nxt);
            end
        end

        // Reset from HALTED, then async reset in the middle of FETCH_LO
        wait_cfg = 0;
        rst = 1'b1;
        step();
        check("rst_unhalt", bus.halted, 1'b0);
        rst = 1'b0;
        exp_q.push_back(16'h34CD);
        lat = 0;
        while (!bus.instr_valid && lat < 20) begin
            step();
            lat++;
        end
        check("rst_latency", lat, 3);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        step();
        check("mid_lo_addr", bus.mem_addr, 8'h03);
        check("mid_lo_instr", bus.instr, 16'h34CD);
        #2;
        rst = 1'b1;
        #1;
        check("async_rd",    bus.mem_rd, 1'b0);
        check("async_en",    bus.pc_enOut, 1'b0);
        check("async_valid", bus.instr_valid, 1'b0);
        check("async_instr", bus.instr, 16'h0000);
        check("async_inc",   bus.pc_inc, 1'b0);
        step();
        rst = 1'b0;

        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
